// File: rtl/wb_uart_pkg.sv
// Shared constants for the Wishbone UART: register map, STATUS/CTRL bit
// positions, FSM state codes and reset values.
package wb_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned ST_RX_AVAIL  = 0;
  localparam int unsigned ST_TX_FULL   = 1;
  localparam int unsigned ST_TX_IDLE   = 2;
  localparam int unsigned ST_RX_OVR    = 3;
  localparam int unsigned ST_FRAME_ERR = 4;

  localparam int unsigned CT_TX_EN   = 0;
  localparam int unsigned CT_RX_EN   = 1;
  localparam int unsigned CT_LOOP    = 2;
  localparam int unsigned CT_RX_IRQ  = 3;
  localparam int unsigned CT_TX_IRQ  = 4;
  localparam int unsigned CTRL_W     = 5;

  localparam logic [CTRL_W-1:0] CTRL_RST = 5'h03;

  // Shared by the TX and RX bit engines
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word fall-through head; a push on a full FIFO
// is accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart.sv
// 8N1 UART behind a single-wait-state Wishbone slave: programmable divisor,
// TX/RX FIFOs, sticky error flags, internal loopback and a level interrupt.
module wb_uart
  import wb_uart_pkg::*;
#(
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 433
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);

  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

  logic              ack_q, irq_q, irq_d, utx_q, utx_d;
  logic [31:0]       dat_q, dat_d, rdata;
  logic [DIV_W-1:0]  div_q, div_d, div_eff, half_m1;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ovr_q, ovr_d, ferr_q, ferr_d, ovr_set, ovr_clr, ferr_set, ferr_clr;
  logic              fire, wr_fire, rd_fire;
  logic [31:0]       lane_mask;

  logic              tx_push, tx_pop, tx_full, tx_empty, tx_idle, tx_load, tx_tick;
  logic [7:0]        tx_head;
  logic [TX_CW-1:0]  tx_count;
  logic [1:0]        tx_state_q, tx_state_d;
  logic [DIV_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              tx_line_q, tx_line_d;

  logic              rx_push, rx_pop, rx_full, rx_empty, rx_avail, rx_tick, rx_fall, rx_src;
  logic [7:0]        rx_head;
  logic [RX_CW-1:0]  rx_count;
  logic [1:0]        rx_state_q, rx_state_d;
  logic [DIV_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_s1_q, rx_s2_q, rx_prev_q;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .push_i(tx_push), .wdata_i(wb_dat_i[7:0]),
    .pop_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .push_i(rx_push), .wdata_i(rx_shift_d),
    .pop_i(rx_pop), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign uart_tx_o = utx_q;
  assign irq_o     = irq_q;

  assign fire      = wb_stb_i & ~ack_q;
  assign wr_fire   = fire & wb_we_i;
  assign rd_fire   = fire & ~wb_we_i;
  assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign div_eff   = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
  assign half_m1   = DIV_W'((({1'b0, div_eff} + (DIV_W+1)'(1)) >> 1) - (DIV_W+1)'(1));
  assign tx_idle   = (tx_count == '0) & (tx_state_q == S_IDLE);
  assign rx_avail  = (rx_count != '0);
  assign rx_src    = ctrl_q[CT_LOOP] ? tx_line_q : uart_rx_i;
  assign rx_fall   = rx_prev_q & ~rx_s2_q;

  // Register file: decode, read mux and all bus side effects on the fire cycle
  always_comb begin
    div_d    = div_q;
    ctrl_d   = ctrl_q;
    rdata    = '0;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    ovr_clr  = 1'b0;
    ferr_clr = 1'b0;
    case (wb_adr_i)
      REG_DATA: begin
        rdata   = {24'h0, rx_empty ? 8'h00 : rx_head};
        tx_push = wr_fire & wb_sel_i[0];
        rx_pop  = rd_fire & ~rx_empty;
      end
      REG_STATUS: begin
        rdata[ST_RX_AVAIL]  = rx_avail;
        rdata[ST_TX_FULL]   = tx_full;
        rdata[ST_TX_IDLE]   = tx_idle;
        rdata[ST_RX_OVR]    = ovr_q;
        rdata[ST_FRAME_ERR] = ferr_q;
        ovr_clr  = wr_fire & wb_sel_i[0] & wb_dat_i[ST_RX_OVR];
        ferr_clr = wr_fire & wb_sel_i[0] & wb_dat_i[ST_FRAME_ERR];
      end
      REG_DIV: begin
        rdata = 32'(div_q);
        if (wr_fire) div_d = (div_q & ~DIV_W'(lane_mask)) | DIV_W'(wb_dat_i & lane_mask);
      end
      default: begin
        rdata = 32'(ctrl_q);
        if (wr_fire && wb_sel_i[0]) ctrl_d = wb_dat_i[CTRL_W-1:0];
      end
    endcase
    dat_d  = fire ? (wb_we_i ? 32'h0 : rdata) : dat_q;
    ovr_d  = (ovr_q & ~ovr_clr) | ovr_set;
    ferr_d = (ferr_q & ~ferr_clr) | ferr_set;
    irq_d  = (ctrl_q[CT_RX_IRQ] & rx_avail) | (ctrl_q[CT_TX_IRQ] & tx_idle) | ovr_q | ferr_q;
  end

  // TX engine; the divisor is reloaded at every bit boundary
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    tx_load    = ctrl_q[CT_TX_EN] & ~tx_empty;
    tx_tick    = (tx_cnt_q == '0);
    if (tx_state_q != S_IDLE && !tx_tick) tx_cnt_d = tx_cnt_q - DIV_W'(1);
    case (tx_state_q)
      S_START: if (tx_tick) begin
        tx_state_d = S_DATA;
        tx_bit_d   = 3'd0;
        tx_cnt_d   = div_eff;
        tx_line_d  = tx_shift_q[0];
      end
      S_DATA: if (tx_tick) begin
        tx_cnt_d = div_eff;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = S_STOP;
          tx_line_d  = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = tx_shift_q >> 1;
          tx_line_d  = tx_shift_q[1];
        end
      end
      default: if ((tx_state_q == S_IDLE) || tx_tick) begin
        tx_state_d = S_IDLE;
        if (tx_load) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = div_eff;
          tx_line_d  = 1'b0;
          tx_state_d = S_START;
        end
      end
    endcase
    utx_d = ctrl_q[CT_LOOP] | tx_line_d;
  end

  // RX engine: start-bit qualification at half a bit, then mid-bit sampling
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    rx_tick    = (rx_cnt_q == '0);
    if (rx_state_q != S_IDLE && !rx_tick) rx_cnt_d = rx_cnt_q - DIV_W'(1);
    case (rx_state_q)
      S_IDLE: if (ctrl_q[CT_RX_EN] && rx_fall) begin
        rx_state_d = S_START;
        rx_cnt_d   = half_m1;
      end
      S_START: if (rx_tick) begin
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        rx_cnt_d   = div_eff;
        rx_bit_d   = 3'd0;
      end
      S_DATA: if (rx_tick) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_cnt_d   = div_eff;
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
      end
      default: if (rx_tick) begin
        rx_state_d = S_IDLE;
        rx_push    = rx_s2_q;
        ferr_set   = ~rx_s2_q;
      end
    endcase
    ovr_set = rx_push & rx_full & ~rx_pop;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
      utx_q      <= 1'b1;
      div_q      <= DIV_W'(DEFAULT_DIV);
      ctrl_q     <= CTRL_RST;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      ack_q      <= fire;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
      utx_q      <= utx_d;
      div_q      <= div_d;
      ctrl_q     <= ctrl_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rx_src;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

endmodule

// File: tb/tb_wb_uart.sv
// Directed-plus-random bench for wb_uart: bus handshake, register map, serial
// waveform, loopback reception, overrun, framing error, glitch and reset abort.
module tb_wb_uart;

  localparam int BP = 4;  // clocks per bit once DIV=3

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  adr;
  logic [31:0] dat_i, dat_o;
  logic        we, stb, ack, tx, rx, irq;
  logic [3:0]  sel;

  int total = 0;
  int bad   = 0;

  logic       cap_en = 1'b0;
  logic       cap_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_model[$];

  always #5 clk = ~clk;

  wb_uart #(.TX_DEPTH(16), .RX_DEPTH(4), .DIV_W(16), .DEFAULT_DIV(433)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_ack_o(ack),
    .uart_tx_o(tx), .uart_rx_i(rx), .irq_o(irq)
  );

  always @(negedge clk) if (cap_en) cap_q.push_back(tx);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
    @(negedge clk);
    check("ack_low_before_stb", 32'(ack), 32'd0);
    stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    @(negedge clk);
    check("ack_one_cycle_after_stb", 32'(ack), 32'd1);
    r = dat_o;
    stb = 1'b0; we = 1'b0; dat_i = '0; sel = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    xfer(1'b1, a, d, s, r);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, a, 32'h0, 4'h0, r);
    check(tag, r, exp);
  endtask

  // Expected line level k clocks after the first start bit, frames back to back
  function automatic logic model_bit(input int k);
    int f, b;
    logic [7:0] v;
    f = k / (10 * BP);
    b = (k % (10 * BP)) / BP;
    if (f >= exp_q.size()) return 1'b1;
    v = exp_q[f];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return v[b-1];
  endfunction

  task automatic check_tx(input string tag);
    int s, n;
    s = -1;
    for (int i = 0; i < cap_q.size(); i++) if (cap_q[i] == 1'b0) begin s = i; break; end
    check({tag, "_start_seen"}, 32'(s >= 0), 32'd1);
    if (s >= 0) begin
      n = exp_q.size() * 10 * BP + 2 * BP;
      check({tag, "_capture_len"}, 32'(cap_q.size() >= s + n), 32'd1);
      for (int k = 0; k < n && s + k < cap_q.size(); k++)
        check($sformatf("%s[%0d]", tag, k), 32'(cap_q[s+k]), 32'(model_bit(k)));
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0; idle(BP);
    for (int i = 0; i < 8; i++) begin rx = b[i]; idle(BP); end
    rx = stop; idle(BP);
    rx = 1'b1;
  endtask

  task automatic send_loop(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (rx_model.size() < 4) rx_model.push_back(b);
      wr(2'd0, 32'(b), 4'h1);
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] div_exp;
    int          zeros;

    rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0; rx = 1'b1;
    idle(3);
    check("rst_tx_high", 32'(tx), 32'd1);
    check("rst_irq_low", 32'(irq), 32'd0);
    check("rst_ack_low", 32'(ack), 32'd0);
    check("rst_dat_zero", dat_o, 32'd0);
    rst = 1'b0;

    rd_chk("rst_data", 2'd0, 32'h0);
    rd_chk("rst_status", 2'd1, 32'h04);
    rd_chk("rst_div", 2'd2, 32'd433);
    rd_chk("rst_ctrl", 2'd3, 32'h3);

    // Held strobe: acks alternate
    @(negedge clk);
    stb = 1'b1; adr = 2'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ack[%0d]", i), 32'(ack), 32'((i % 2) == 0));
      if (ack) check("b2b_data", dat_o, 32'h3);
    end
    stb = 1'b0;

    div_exp = (16'd433 & 16'h00FF) | 16'hAB00;
    wr(2'd2, 32'h0000ABCD, 4'b0010);
    rd_chk("div_lane1", 2'd2, 32'(div_exp));
    wr(2'd2, 32'h3, 4'b0011);
    rd_chk("div_set3", 2'd2, 32'h3);

    // TX waveform: 0x55 followed by a random byte with no gap
    b = 8'($urandom);
    exp_q.push_back(8'h55); exp_q.push_back(b);
    cap_q.delete(); cap_en = 1'b1;
    wr(2'd0, 32'h55, 4'h1);
    wr(2'd0, 32'(b), 4'h1);
    idle(100);
    cap_en = 1'b0;
    check_tx("tx_wave");
    rd_chk("tx_idle_after", 2'd1, 32'h04);

    // Loopback: line held high, bytes come back in order
    wr(2'd3, 32'h7, 4'h1);
    cap_q.delete(); cap_en = 1'b1;
    wr(2'd0, 32'hA5, 4'h1);
    wr(2'd0, 32'h3C, 4'h1);
    idle(120);
    cap_en = 1'b0;
    zeros = 0;
    foreach (cap_q[i]) if (cap_q[i] == 1'b0) zeros++;
    cap_q.delete();
    check("loop_tx_held_high", 32'(zeros), 32'd0);
    rd_chk("loop_status", 2'd1, 32'h05);
    rd_chk("loop_rx0", 2'd0, 32'hA5);
    rd_chk("loop_rx1", 2'd0, 32'h3C);
    rd_chk("loop_empty_read", 2'd0, 32'h0);
    rd_chk("loop_status_empty", 2'd1, 32'h04);

    rx_model.delete();
    send_loop(3);
    idle(150);
    while (rx_model.size() > 0) rd_chk("loop_rand", 2'd0, 32'(rx_model.pop_front()));

    // Overrun: five frames into a four-entry RX FIFO
    send_loop(5);
    idle(240);
    rd_chk("ovr_status", 2'd1, 32'h0D);
    check("ovr_irq", 32'(irq), 32'd1);
    while (rx_model.size() > 0) rd_chk("ovr_kept", 2'd0, 32'(rx_model.pop_front()));
    rd_chk("ovr_status_drained", 2'd1, 32'h0C);
    wr(2'd1, 32'h08, 4'h1);
    rd_chk("ovr_cleared", 2'd1, 32'h04);
    idle(2);
    check("ovr_irq_cleared", 32'(irq), 32'd0);

    // Framing error from the pin
    wr(2'd3, 32'h3, 4'h1);
    drive_rx_frame(8'($urandom), 1'b0);
    idle(10);
    rd_chk("ferr_status", 2'd1, 32'h14);
    check("ferr_irq", 32'(irq), 32'd1);
    wr(2'd1, 32'h10, 4'h1);
    rd_chk("ferr_cleared", 2'd1, 32'h04);

    // One-clock glitch is ignored; a clean frame afterwards is received
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    idle(20);
    rd_chk("glitch_status", 2'd1, 32'h04);
    b = 8'($urandom);
    drive_rx_frame(b, 1'b1);
    idle(10);
    rd_chk("pin_rx_status", 2'd1, 32'h05);
    rd_chk("pin_rx_data", 2'd0, 32'(b));
    check("pin_rx_irq", 32'(irq), 32'd0);

    // Reset in the middle of a frame with bytes still queued
    wr(2'd0, 32'h00, 4'h1);
    wr(2'd0, 32'h00, 4'h1);
    wr(2'd0, 32'h00, 4'h1);
    @(negedge clk);
    check("tx_low_before_reset", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("tx_high_after_reset", 32'(tx), 32'd1);
    rst = 1'b0;
    rd_chk("reset_status", 2'd1, 32'h04);
    rd_chk("reset_div", 2'd2, 32'd433);
    rd_chk("reset_ctrl", 2'd3, 32'h3);
    wr(2'd2, 32'h3, 4'h3);
    b = 8'($urandom);
    exp_q.push_back(b);
    cap_q.delete(); cap_en = 1'b1;
    wr(2'd0, 32'(b), 4'h1);
    idle(60);
    cap_en = 1'b0;
    check_tx("tx_after_reset");
    rd_chk("final_status", 2'd1, 32'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
